rv32_insn_encoder: RTL and testbench

//  Encoder counterpart of the Rv32ic field-decode view: packs per-field operands (format, opcode,

---
 rtl/rv32_insn_encoder.sv | 136 +++++++++++++
 tb/tb_rv32_insn_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_insn_encoder.sv
// RV32I instruction word encoder with immediate range checking.
// Encoded words and error flags queue in a small valid/ready FIFO.
module rv32_insn_encoder #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic sx11, sx12, sx20;
  logic legal;
  logic [31:0] enc;
  logic [32:0] ent;
  logic [32:0] head;

  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign is_r = in_fmt == 3'd0;
  assign is_i = in_fmt == 3'd1;
  assign is_s = in_fmt == 3'd2;
  assign is_b = in_fmt == 3'd3;
  assign is_u = in_fmt == 3'd4;
  assign is_j = in_fmt == 3'd5;

  // immediate fits when all bits above the field are sign copies
  assign sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sx12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    unique case (1'b1)
      is_r: begin
        enc = {in_funct7, in_rs2, in_rs1,
               in_funct3, in_rd, in_opcode};
        legal = 1'b1;
      end
      is_i: begin
        enc = {in_imm[11:0], in_rs1,
               in_funct3, in_rd, in_opcode};
        legal = sx11;
      end
      is_s: begin
        enc = {in_imm[11:5], in_rs2, in_rs1,
               in_funct3, in_imm[4:0], in_opcode};
        legal = sx11;
      end
      is_b: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2,
               in_rs1, in_funct3, in_imm[4:1],
               in_imm[11], in_opcode};
        legal = sx12 & ~in_imm[0];
      end
      is_u: begin
        enc = {in_imm[31:12], in_rd, in_opcode};
        legal = ~(|in_imm[11:0]);
      end
      is_j: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11],
               in_imm[19:12], in_rd, in_opcode};
        legal = sx20 & ~in_imm[0];
      end
      default: ;
    endcase
    if (in_opcode[1:0] != 2'b11) legal = 1'b0;
  end

  assign ent = legal ? {1'b0, enc} : {1'b1, 32'h0};

  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head     = mem[rd_ptr];
  assign out_insn = out_valid ? head[31:0] : 32'h0;
  assign out_err  = out_valid & head[32];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      // a flushed push is dropped but its error is still counted
      if (push && !legal && err_cnt != {ERR_W{1'b1}})
        err_cnt <= err_cnt + ERR_W'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32_insn_encoder.sv
// Randomized check of rv32_insn_encoder against a queue-based model.
// Directed vectors pin both the model and the DUT.
module tb_rv32_insn_encoder;

  localparam int DEPTH = 2;
  localparam int ERR_W = 4;
  localparam int CMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             in_valid, in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid, out_ready;
  logic [31:0]      out_insn;
  logic             out_err;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [32:0] q[$];
  int          m_cnt;
  logic [32:0] h;
  logic [32:0] r;
  logic        m_push;

  logic [31:0] edges [14] = '{
    32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
    32'd4094, 32'd4095, 32'd4096, -32'sd4096,
    -32'sd4098, 32'h000F_FFFE, 32'h0010_0000,
    -32'sd1048576, 32'h1234_5000, 32'hFFFF_F000
  };

  always #5 clk = ~clk;

  rv32_insn_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_insn(out_insn),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  function automatic logic [32:0] ref_enc(
    input logic [2:0] fmt, input logic [31:0] op,
    input logic [31:0] rd, input logic [31:0] rs1,
    input logic [31:0] rs2, input logic [31:0] f3,
    input logic [31:0] f7, input logic [31:0] imm);
    int s;
    bit ok;
    logic [31:0] w;
    logic [31:0] base;
    s = $signed(imm);
    w = 0;
    ok = 0;
    base = (rs1 << 15) | (f3 << 12) | op;
    case (fmt)
      3'd0: begin
        ok = 1;
        w = (f7 << 25) | (rs2 << 20) | base | (rd << 7);
      end
      3'd1: begin
        ok = s >= -2048 && s <= 2047;
        w = ((imm % 4096) << 20) | base | (rd << 7);
      end
      3'd2: begin
        ok = s >= -2048 && s <= 2047;
        w = (((imm / 32) % 128) << 25) | (rs2 << 20)
          | base | ((imm % 32) << 7);
      end
      3'd3: begin
        ok = s >= -4096 && s <= 4095 && s % 2 == 0;
        w = (((imm >> 12) & 1) << 31)
          | (((imm >> 5) % 64) << 25) | (rs2 << 20) | base
          | (((imm >> 1) % 16) << 8) | (((imm >> 11) & 1) << 7);
      end
      3'd4: begin
        ok = imm % 4096 == 0;
        w = ((imm / 4096) << 12) | (rd << 7) | op;
      end
      3'd5: begin
        ok = s >= -1048576 && s < 1048576 && s % 2 == 0;
        w = (((imm >> 20) & 1) << 31)
          | (((imm >> 1) % 1024) << 21)
          | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) % 256) << 12) | (rd << 7) | op;
      end
      default: ok = 0;
    endcase
    if (op % 4 != 3) ok = 0;
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  // model state advances on each active edge
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      m_push = in_valid && q.size() < DEPTH;
      r = ref_enc(in_fmt, 32'(in_opcode), 32'(in_rd),
                  32'(in_rs1), 32'(in_rs2), 32'(in_funct3),
                  32'(in_funct7), in_imm);
      if (m_push && r[32] && m_cnt < CMAX) m_cnt++;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (m_push) q.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      h = q.size() > 0 ? q[0] : 33'h0;
      checks++;
      if (out_valid !== (q.size() > 0)
          || in_ready !== (q.size() < DEPTH)
          || out_insn !== h[31:0] || out_err !== h[32]
          || err_cnt !== ERR_W'(m_cnt)) begin
        errors++;
        $display("FAIL model t=%0t v=%b/%b rdy=%b/%b insn=%h/%h err=%b/%b cnt=%0d/%0d",
                 $time, out_valid, q.size() > 0, in_ready,
                 q.size() < DEPTH, out_insn, h[31:0], out_err,
                 h[32], err_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] f, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] a,
                     input logic [4:0] b, input logic [2:0] f3,
                     input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = a;
    in_rs2 = b; in_funct3 = f3; in_funct7 = 7'h0;
    in_imm = imm;
  endtask

  task automatic put_i(); put(1, 7'h13, 1, 2, 0, 0, 5); endtask
  task automatic put_s(); put(2, 7'h23, 0, 2, 5, 2, -4); endtask
  task automatic put_u(); put(4, 7'h37, 3, 0, 0, 0, 32'h12345000); endtask

  task automatic send_chk(input string nm, input logic [31:0] exp,
                          input logic e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_insn"}, out_insn, exp);
    chk({nm, "_err"}, 32'(out_err), 32'(e));
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 6))
      0: return 32'($signed($urandom_range(0, 40)) - 20);
      1, 2: return edges[$urandom_range(0, 13)];
      3: return v & 32'hFFFF_F000;
      4: return 32'($signed(v[20:0])) & ~32'h1;
      5: return 32'($signed(v[12:0]));
      default: return v;
    endcase
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_insn", out_insn, 0);
    chk("rst_cnt", 32'(err_cnt), 0);

    r = ref_enc(1, 'h13, 1, 2, 0, 0, 0, 5);
    chk("model_i", r[31:0], 32'h00510093);
    r = ref_enc(2, 'h23, 0, 2, 5, 2, 0, -4);
    chk("model_s", r[31:0], 32'hFE512E23);
    r = ref_enc(4, 'h37, 3, 0, 0, 0, 0, 32'h12345000);
    chk("model_u", r[31:0], 32'h123451B7);
    r = ref_enc(5, 'h6F, 1, 0, 0, 0, 0, 32'h800);
    chk("model_j", r[31:0], 32'h001000EF);
    r = ref_enc(5, 'h6F, 1, 0, 0, 0, 0, 32'h801);
    chk("model_jerr", 32'(r[32]), 1);

    tick();
    put_i();
    send_chk("i", 32'h00510093, 0);
    tick(); put_s();
    send_chk("s", 32'hFE512E23, 0);
    tick(); put_u();
    send_chk("u", 32'h123451B7, 0);
    tick(); put(5, 7'h6F, 1, 0, 0, 0, 32'h800);
    send_chk("j", 32'h001000EF, 0);
    tick(); put(5, 7'h6F, 1, 0, 0, 0, 32'h801);
    send_chk("jbad", 32'h0, 1);
    chk("jbad_cnt", 32'(err_cnt), 1);
    tick();

    out_ready = 1'b0;
    put_i(); in_valid = 1'b1;
    tick(); put_s();
    tick();
    chk("full_ready", 32'(in_ready), 0);
    put_u();
    tick();
    chk("full_hold", 32'(in_ready), 0);
    chk("full_head", out_insn, 32'h00510093);
    out_ready = 1'b1;
    tick();
    chk("pop_only_ready", 32'(in_ready), 1);
    chk("pop_only_head", out_insn, 32'hFE512E23);
    tick();
    in_valid = 1'b0;
    chk("third_head", out_insn, 32'h123451B7);
    tick();
    chk("drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    put_i(); in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    tick();
    chk("flush_stale", 32'(out_valid), 0);
    put(6, 7'h33, 1, 1, 1, 0, 0);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop", 32'(out_valid), 0);
    chk("flush_cnt", 32'(err_cnt), 2);

    put_s(); in_valid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    tick();
    chk("mid_rst_stale", 32'(out_valid), 0);

    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 19) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < (i % 800 < 400 ? 6 : 2);
      in_fmt = 3'($urandom_range(0, 7));
      in_opcode = 7'($urandom);
      if ($urandom_range(0, 7) != 0) in_opcode[1:0] = 2'b11;
      in_rd = 5'($urandom); in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom); in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm = pick_imm();
    end
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
